flash_refill: RTL
=================

# flash_refill

Miss-refill engine on the flash side of the SRAM cache controller. When the read controller reports a miss, the block fetches the aligned `SUB_DEPTH`-word block containing the missed address from flash. It writes the block into the least-recently-used sub-SRAM and forwards the critical word. It then reports the new block base so the controller can update its sub-SRAM address tags.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: word address width.
- `DATA_WIDTH`, 32: data word width.
- `SUB_NUM`, 4: number of sub-SRAMs. Fixed at 4 in this revision.
- `SUB_DEPTH`, 64: words per sub-SRAM. Must be a power of 2.

Ports:
- `clk`  in  1: single clock. All logic is on the rising edge.
- `grst`  in  1: reset. Synchronous, active-high.
- `miss_req`  in  1: miss pending. Level signal, held until `miss_ack`.
- `miss_addr`  in  `ADDR_WIDTH`: missed word address. Valid while `miss_req` is high.
- `miss_ack`  out  1: one-cycle pulse. The miss has been accepted.
- `hit_valid`  in  1: the controller served a hit from a sub-SRAM.
- `hit_sub`  in  2: index of the sub-SRAM that hit.
- `flash_req`  out  1: flash word read request.
- `flash_addr`  out  `ADDR_WIDTH`: flash word address.
- `flash_ready`  in  1: flash accepts the request.
- `flash_rvalid`  in  1: flash read data valid.
- `flash_rdata`  in  `DATA_WIDTH`: flash read data.
- `ram_we`  out  1: SRAM write strobe.
- `ram_sel`  out  `SUB_NUM+1`: one-hot SRAM select. Bit 0 is the main SRAM and is never driven by this block. Bit i+1 is sub-SRAM i.
- `ram_waddr`  out  `ADDR_WIDTH`: local word offset inside the selected SRAM, zero-extended.
- `ram_wdata`  out  `DATA_WIDTH`: SRAM write data.
- `crit_valid`  out  1: one-cycle pulse. `crit_data` holds the missed word.
- `crit_data`  out  `DATA_WIDTH`: the missed word.
- `fill_done`  out  1: one-cycle pulse. The refill is complete.
- `fill_sub`  out  2: index of the sub-SRAM that was filled. Valid with `fill_done`.
- `fill_base`  out  `ADDR_WIDTH`: base address of the filled block. Valid with `fill_done`.
- `busy`  out  1: high in every state other than IDLE.

## Operation
- Base address: `base = miss_addr & ~(SUB_DEPTH-1)`.
- Critical offset: `crit_off = miss_addr[log2(SUB_DEPTH)-1:0]`.
- Word counter `cnt` is `log2(SUB_DEPTH)` bits wide. `flash_addr = base + cnt`.
- State machine states: IDLE, REQ, WAIT, WR, DONE.
  - IDLE, with `miss_req` high: latch `base` and `crit_off`, latch `victim` from the LRU, clear `cnt`, go to REQ.
  - REQ: `flash_req` = 1. When `flash_ready` is high, go to WAIT.
  - WAIT: when `flash_rvalid` is high, register `flash_rdata` and go to WR.
  - WR: `ram_we` = 1, `ram_sel` = 1 << (victim+1), `ram_waddr` = `cnt`, `ram_wdata` = registered data. When `cnt == crit_off`, also `crit_valid` = 1 with the same data. If `cnt == SUB_DEPTH-1`, go to DONE. Otherwise increment `cnt` and go to REQ.
  - DONE: `fill_done` = 1 with `fill_sub` = victim and `fill_base` = base. Mark victim as MRU. Go to IDLE.
- `miss_ack` is high in the first REQ cycle after acceptance.
- `miss_req` is ignored while `busy` is high.
- `flash_rvalid` is ignored outside WAIT.
- This block does no range check on `miss_addr`. Range checking is the controller's responsibility.
- LRU ordering:
  - `hit_valid` marks `hit_sub` as MRU in any state.
  - If a hit and DONE occur in the same cycle, apply the hit first, then the fill. The filled sub ends as MRU.
  - Reset order, LRU to MRU: 0, 1, 2, 3. The first four victims are therefore 0, 1, 2, 3.
- Reset mid-refill:
  - The next edge returns the block to IDLE and clears every output to 0 (no partial `fill_done`).
  - The LRU returns to the reset order.
  - SRAM contents already written are left as they are. The controller's tags are not updated.

## Timing
- Reset value of every output is 0.
- Outputs are registered or decoded from the state register only. There is no combinational path from inputs to outputs.
- Refill with zero flash stalls:
  - Edge 0: IDLE samples `miss_req`.
  - Cycle 1: REQ, with `miss_ack`.
  - Each word takes 3 cycles (REQ, WAIT, WR).
  - `fill_done` is in cycle `3*SUB_DEPTH+1`. For `SUB_DEPTH` = 64 this is cycle 193.
- `flash_req` and `flash_addr` are held stable through REQ until `flash_ready`. Each wait cycle adds one cycle.
- The earliest next accepted miss is sampled in the IDLE cycle right after DONE.

## Structure
- Shared defines: `ADDR_WIDTH`, `DATA_WIDTH`, `SUB_NUM`, `SUB_DEPTH`, and the `SUBn_CHOSEN` one-hot constants.
- Local: state encodings.
- Sub-module `lru4`: 4-entry LRU tracker.
  - Inputs: two prioritised touch ports, hit then fill.
  - Output: `victim`.
  - Implementation: 6-bit pairwise-age matrix.

## Test plan
- Basic fill: reset, then `miss_addr` = 0x1234 with no stalls.
  - Flash addresses 0x1200..0x123F in order.
  - 64 writes with `ram_sel` = 5'b00010 and offsets 0..63.
  - `crit_valid` at offset 0x34, with data equal to flash word 0x1234.
  - `fill_done` in cycle 193 with `fill_sub` = 0 and `fill_base` = 0x1200.
- Four back-to-back misses: victims are 0, 1, 2, 3. Then `hit_valid` with `hit_sub` = 0: the next miss victim is 1.
- `flash_ready` held low for 5 cycles on word 7: `flash_req`/`flash_addr` (0x1207) stay stable, and `fill_done` arrives 5 cycles later than baseline.
- `miss_req` asserted while busy: no `miss_ack` until the cycle after DONE, then normal acceptance.
- `grst` during WR of word 10: all outputs 0 on the next cycle. A new miss restarts at its base with victim 0.
- `hit_valid` with `hit_sub` = 3 in the DONE cycle of a fill into sub 1: subs 1 and 3 are MRU and second, so the next two victims are 0 and 2.

Source files
------------

// File: rtl/flash_refill_pkg.sv
//------------------------------------------------------------------------------
// Module   : flash_refill_pkg
// Purpose  : Shared sizes and sub-SRAM one-hot select constants for the
//            flash-side miss-refill engine.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package flash_refill_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int SUB_NUM    = 4;
  localparam int SUB_DEPTH  = 64;

  // Bit 0 of the SRAM select is the main SRAM; sub-SRAM n sits at bit n+1.
  localparam logic [SUB_NUM:0] SUB0_CHOSEN = 5'b00010;
  localparam logic [SUB_NUM:0] SUB1_CHOSEN = 5'b00100;
  localparam logic [SUB_NUM:0] SUB2_CHOSEN = 5'b01000;
  localparam logic [SUB_NUM:0] SUB3_CHOSEN = 5'b10000;

  // One-hot SRAM select for a sub-SRAM index.
  function automatic logic [SUB_NUM:0] sub_chosen(input logic [1:0] idx);
    case (idx)
      2'd0:    return SUB0_CHOSEN;
      2'd1:    return SUB1_CHOSEN;
      2'd2:    return SUB2_CHOSEN;
      default: return SUB3_CHOSEN;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/flash_refill_lru4.sv
//------------------------------------------------------------------------------
// Module   : lru4
// Purpose  : 4-entry LRU tracker using a 6-bit pairwise-age matrix with two
//            prioritised touch ports (a applied first, then b).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lru4 (
  input  logic       clk,
  input  logic       grst,
  input  logic       touch_a_i,
  input  logic [1:0] touch_a_idx_i,
  input  logic       touch_b_i,
  input  logic [1:0] touch_b_idx_i,
  output logic [1:0] victim_o
);

  // Matrix bit set means the lower-indexed entry of the pair is older.
  // Pair order: [0]=(0,1) [1]=(0,2) [2]=(0,3) [3]=(1,2) [4]=(1,3) [5]=(2,3)
  localparam logic [5:0] C_RESET_AGE = 6'b111111;

  logic [5:0] age_q;
  logic [5:0] age_d;

  // Make entry k the most recently used: older than nobody.
  function automatic logic [5:0] touch(input logic [5:0] m, input logic [1:0] k);
    logic [5:0] r;
    r = m;
    case (k)
      2'd0: begin r[0] = 1'b0; r[1] = 1'b0; r[2] = 1'b0; end
      2'd1: begin r[0] = 1'b1; r[3] = 1'b0; r[4] = 1'b0; end
      2'd2: begin r[1] = 1'b1; r[3] = 1'b1; r[5] = 1'b0; end
      default: begin r[2] = 1'b1; r[4] = 1'b1; r[5] = 1'b1; end
    endcase
    return r;
  endfunction

  // Apply port a then port b so that b wins when both touch.
  always_comb begin
    age_d = age_q;
    if (touch_a_i) age_d = touch(age_d, touch_a_idx_i);
    if (touch_b_i) age_d = touch(age_d, touch_b_idx_i);
  end

  // Age matrix register; reset order LRU->MRU is 0,1,2,3.
  always_ff @(posedge clk) begin
    if (grst) age_q <= C_RESET_AGE;
    else      age_q <= age_d;
  end

  // Victim is the entry older than all three others.
  always_comb begin
    if (age_q[0] & age_q[1] & age_q[2])        victim_o = 2'd0;
    else if (~age_q[0] & age_q[3] & age_q[4])  victim_o = 2'd1;
    else if (~age_q[1] & ~age_q[3] & age_q[5]) victim_o = 2'd2;
    else                                       victim_o = 2'd3;
  end

endmodule

`default_nettype wire

// File: rtl/flash_refill.sv
//------------------------------------------------------------------------------
// Module   : flash_refill
// Purpose  : Miss-refill engine. Fetches the aligned SUB_DEPTH-word block
//            around a missed address from flash, writes it into the LRU
//            sub-SRAM, forwards the critical word and reports the new base.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module flash_refill #(
  parameter int ADDR_WIDTH = flash_refill_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = flash_refill_pkg::DATA_WIDTH,
  parameter int SUB_NUM    = flash_refill_pkg::SUB_NUM,
  parameter int SUB_DEPTH  = flash_refill_pkg::SUB_DEPTH
) (
  input  logic                  clk,
  input  logic                  grst,
  input  logic                  miss_req,
  input  logic [ADDR_WIDTH-1:0] miss_addr,
  output logic                  miss_ack,
  input  logic                  hit_valid,
  input  logic [1:0]            hit_sub,
  output logic                  flash_req,
  output logic [ADDR_WIDTH-1:0] flash_addr,
  input  logic                  flash_ready,
  input  logic                  flash_rvalid,
  input  logic [DATA_WIDTH-1:0] flash_rdata,
  output logic                  ram_we,
  output logic [SUB_NUM:0]      ram_sel,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  crit_valid,
  output logic [DATA_WIDTH-1:0] crit_data,
  output logic                  fill_done,
  output logic [1:0]            fill_sub,
  output logic [ADDR_WIDTH-1:0] fill_base,
  output logic                  busy
);

  import flash_refill_pkg::*;

  localparam int CW = $clog2(SUB_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] C_OFF_MASK = ADDR_WIDTH'(SUB_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                state_q;
  logic [CW-1:0]         cnt_q;
  logic [CW-1:0]         cnt_d;
  logic [CW-1:0]         crit_off_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [1:0]            victim_q;
  logic [1:0]            lru_victim;
  logic [ADDR_WIDTH-1:0] miss_base;

  logic                  miss_ack_q;
  logic                  flash_req_q;
  logic [ADDR_WIDTH-1:0] flash_addr_q;
  logic                  ram_we_q;
  logic [SUB_NUM:0]      ram_sel_q;
  logic [ADDR_WIDTH-1:0] ram_waddr_q;
  logic [DATA_WIDTH-1:0] ram_wdata_q;
  logic                  crit_valid_q;
  logic [DATA_WIDTH-1:0] crit_data_q;
  logic                  fill_done_q;
  logic [1:0]            fill_sub_q;
  logic [ADDR_WIDTH-1:0] fill_base_q;

  assign cnt_d     = cnt_q + 1'b1;
  assign miss_base = miss_addr & ~C_OFF_MASK;

  // Hits and the completed fill both refresh the LRU; the fill wins a tie.
  lru4 u_lru (
    .clk           (clk),
    .grst          (grst),
    .touch_a_i     (hit_valid),
    .touch_a_idx_i (hit_sub),
    .touch_b_i     (state_q == S_DONE),
    .touch_b_idx_i (victim_q),
    .victim_o      (lru_victim)
  );

  // Refill sequencer: every output is set on the transition into its state.
  always_ff @(posedge clk) begin
    if (grst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      crit_off_q   <= '0;
      base_q       <= '0;
      victim_q     <= '0;
      miss_ack_q   <= 1'b0;
      flash_req_q  <= 1'b0;
      flash_addr_q <= '0;
      ram_we_q     <= 1'b0;
      ram_sel_q    <= '0;
      ram_waddr_q  <= '0;
      ram_wdata_q  <= '0;
      crit_valid_q <= 1'b0;
      crit_data_q  <= '0;
      fill_done_q  <= 1'b0;
      fill_sub_q   <= '0;
      fill_base_q  <= '0;
    end else begin
      miss_ack_q   <= 1'b0;
      ram_we_q     <= 1'b0;
      crit_valid_q <= 1'b0;
      fill_done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (miss_req) begin
            base_q       <= miss_base;
            crit_off_q   <= miss_addr[CW-1:0];
            victim_q     <= lru_victim;
            cnt_q        <= '0;
            miss_ack_q   <= 1'b1;
            flash_req_q  <= 1'b1;
            flash_addr_q <= miss_base;
            state_q      <= S_REQ;
          end
        end
        S_REQ: begin
          if (flash_ready) begin
            flash_req_q <= 1'b0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (flash_rvalid) begin
            ram_we_q     <= 1'b1;
            ram_sel_q    <= sub_chosen(victim_q);
            ram_waddr_q  <= ADDR_WIDTH'(cnt_q);
            ram_wdata_q  <= flash_rdata;
            crit_valid_q <= (cnt_q == crit_off_q);
            if (cnt_q == crit_off_q) crit_data_q <= flash_rdata;
            state_q      <= S_WR;
          end
        end
        S_WR: begin
          ram_sel_q <= '0;
          if (&cnt_q) begin
            fill_done_q <= 1'b1;
            fill_sub_q  <= victim_q;
            fill_base_q <= base_q;
            state_q     <= S_DONE;
          end else begin
            cnt_q        <= cnt_d;
            flash_req_q  <= 1'b1;
            flash_addr_q <= base_q + ADDR_WIDTH'(cnt_d);
            state_q      <= S_REQ;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign miss_ack   = miss_ack_q;
  assign flash_req  = flash_req_q;
  assign flash_addr = flash_addr_q;
  assign ram_we     = ram_we_q;
  assign ram_sel    = ram_sel_q;
  assign ram_waddr  = ram_waddr_q;
  assign ram_wdata  = ram_wdata_q;
  assign crit_valid = crit_valid_q;
  assign crit_data  = crit_data_q;
  assign fill_done  = fill_done_q;
  assign fill_sub   = fill_sub_q;
  assign fill_base  = fill_base_q;
  assign busy       = (state_q != S_IDLE);

endmodule

`default_nettype wire
